// File: rtl/systolic_feeder_2x2.sv
// Operand sequencer for a 2x2 systolic array: stores A and B, then feeds them with diagonal skew.
// Optional build macro SYSTOLIC_FEEDER_AUTO_START_EN: a run starts on its own once all 8 elements are written.
module systolic_feeder_2x2 #(
    parameter int WIDTH        = 8,
    parameter int DRAIN_CYCLES = 2
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             load_valid_i,
    output logic             load_ready_o,
    input  logic             load_sel_i,
    input  logic [1:0]       load_addr_i,
    input  logic [WIDTH-1:0] load_data_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             acc_clear_o,
    output logic [WIDTH-1:0] a_data0_o,
    output logic [WIDTH-1:0] a_data1_o,
    output logic [WIDTH-1:0] b_data0_o,
    output logic [WIDTH-1:0] b_data1_o,
    output logic             valid_out_o
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_FEED  = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_e;

    localparam logic [3:0] DRAIN_LAST = 4'(DRAIN_CYCLES - 1);

    state_e           state_q;
    logic [1:0]       beat_q;
    logic [3:0]       drain_q;
    logic [WIDTH-1:0] a_mem_q [4];
    logic [WIDTH-1:0] b_mem_q [4];

    logic             busy_q;
    logic             done_q;
    logic             acc_clear_q;
    logic             valid_q;
    logic [WIDTH-1:0] a_data0_q;
    logic [WIDTH-1:0] a_data1_q;
    logic [WIDTH-1:0] b_data0_q;
    logic [WIDTH-1:0] b_data1_q;

    logic             idle_s;
    logic             auto_go_s;
    logic             run_go_s;
    logic             load_acc_s;
    logic [1:0]       next_beat_s;
    logic [WIDTH-1:0] a_data0_d;
    logic [WIDTH-1:0] a_data1_d;
    logic [WIDTH-1:0] b_data0_d;
    logic [WIDTH-1:0] b_data1_d;

    assign idle_s       = (state_q == S_IDLE);
    assign run_go_s     = idle_s && (start_i || auto_go_s);
    assign load_ready_o = idle_s && !start_i && !auto_go_s;
    assign load_acc_s   = load_valid_i && load_ready_o;

`ifdef SYSTOLIC_FEEDER_AUTO_START_EN
    logic [7:0] mask_q;

    assign auto_go_s = (mask_q == 8'hFF);

    // Written-element mask: one bit per {sel, addr}, emptied when a run begins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            mask_q <= 8'h00;
        end else if (run_go_s) begin
            mask_q <= 8'h00;
        end else if (load_acc_s) begin
            mask_q[{load_sel_i, load_addr_i}] <= 1'b1;
        end else begin
            mask_q <= mask_q;
        end
    end
`else
    assign auto_go_s = 1'b0;
`endif

    // Operand storage; elements persist across runs until rewritten or reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < 4; i++) begin
                a_mem_q[i] <= '0;
                b_mem_q[i] <= '0;
            end
        end else if (load_acc_s) begin
            if (load_sel_i) begin
                b_mem_q[load_addr_i] <= load_data_i;
            end else begin
                a_mem_q[load_addr_i] <= load_data_i;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                a_mem_q[i] <= a_mem_q[i];
                b_mem_q[i] <= b_mem_q[i];
            end
        end
    end

    // Skewed operands for the beat about to be presented; row/column 1 lag by one beat.
    always_comb begin
        a_data0_d   = '0;
        a_data1_d   = '0;
        b_data0_d   = '0;
        b_data1_d   = '0;
        next_beat_s = (state_q == S_CLEAR) ? 2'd0 : (beat_q + 2'd1);
        if (next_beat_s < 2'd2) begin
            a_data0_d = a_mem_q[{1'b0, next_beat_s[0]}];
            b_data0_d = b_mem_q[{next_beat_s[0], 1'b0}];
        end else begin
            a_data0_d = '0;
            b_data0_d = '0;
        end
        if ((next_beat_s == 2'd1) || (next_beat_s == 2'd2)) begin
            a_data1_d = a_mem_q[{1'b1, next_beat_s[1]}];
            b_data1_d = b_mem_q[{next_beat_s[1], 1'b1}];
        end else begin
            a_data1_d = '0;
            b_data1_d = '0;
        end
    end

    // Run sequencer; outputs are loaded on the edge that enters the state they describe.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= S_IDLE;
            beat_q      <= 2'd0;
            drain_q     <= 4'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            acc_clear_q <= 1'b0;
            valid_q     <= 1'b0;
            a_data0_q   <= '0;
            a_data1_q   <= '0;
            b_data0_q   <= '0;
            b_data1_q   <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_go_s) begin
                        state_q     <= S_CLEAR;
                        acc_clear_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end else begin
                        state_q <= S_IDLE;
                    end
                end
                S_CLEAR: begin
                    state_q     <= S_FEED;
                    acc_clear_q <= 1'b0;
                    beat_q      <= 2'd0;
                    valid_q     <= 1'b1;
                    a_data0_q   <= a_data0_d;
                    a_data1_q   <= a_data1_d;
                    b_data0_q   <= b_data0_d;
                    b_data1_q   <= b_data1_d;
                end
                S_FEED: begin
                    if (beat_q == 2'd2) begin
                        state_q   <= S_DRAIN;
                        drain_q   <= 4'd0;
                        valid_q   <= 1'b0;
                        a_data0_q <= '0;
                        a_data1_q <= '0;
                        b_data0_q <= '0;
                        b_data1_q <= '0;
                    end else begin
                        beat_q    <= next_beat_s;
                        a_data0_q <= a_data0_d;
                        a_data1_q <= a_data1_d;
                        b_data0_q <= b_data0_d;
                        b_data1_q <= b_data1_d;
                    end
                end
                S_DRAIN: begin
                    if (drain_q == DRAIN_LAST) begin
                        state_q <= S_DONE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end else begin
                        drain_q <= drain_q + 4'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q     <= S_IDLE;
                    busy_q      <= 1'b0;
                    done_q      <= 1'b0;
                    acc_clear_q <= 1'b0;
                    valid_q     <= 1'b0;
                    a_data0_q   <= '0;
                    a_data1_q   <= '0;
                    b_data0_q   <= '0;
                    b_data1_q   <= '0;
                end
            endcase
        end
    end

    assign busy_o      = busy_q;
    assign done_o      = done_q;
    assign acc_clear_o = acc_clear_q;
    assign valid_out_o = valid_q;
    assign a_data0_o   = a_data0_q;
    assign a_data1_o   = a_data1_q;
    assign b_data0_o   = b_data0_q;
    assign b_data1_o   = b_data1_q;

endmodule

// File: tb/tb_systolic_feeder_2x2.sv
// Randomized bench for systolic_feeder_2x2 against a cycle-schedule model plus a matrix-product check.
module tb_systolic_feeder_2x2;

    localparam int W = 8;
    localparam int D = 2;

    logic         clk_i        = 1'b0;
    logic         rst_ni       = 1'b1;
    logic         load_valid_i = 1'b0;
    logic         load_sel_i   = 1'b0;
    logic [1:0]   load_addr_i  = 2'd0;
    logic [W-1:0] load_data_i  = '0;
    logic         start_i      = 1'b0;
    logic         load_ready_o, busy_o, done_o, acc_clear_o, valid_out_o;
    logic [W-1:0] a_data0_o, a_data1_o, b_data0_o, b_data1_o;

    systolic_feeder_2x2 #(.WIDTH(W), .DRAIN_CYCLES(D)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .load_valid_i (load_valid_i),
        .load_ready_o (load_ready_o),
        .load_sel_i   (load_sel_i),
        .load_addr_i  (load_addr_i),
        .load_data_i  (load_data_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .acc_clear_o  (acc_clear_o),
        .a_data0_o    (a_data0_o),
        .a_data1_o    (a_data1_o),
        .b_data0_o    (b_data0_o),
        .b_data1_o    (b_data1_o),
        .valid_out_o  (valid_out_o)
    );

    always #5 clk_i = ~clk_i;

    logic [4*W+3:0] obs_s;
    assign obs_s = {acc_clear_o, busy_o, done_o, valid_out_o, a_data0_o, a_data1_o, b_data0_o, b_data1_o};

    int n_chk  = 0;
    int n_pass = 0;

    // Model: stored matrices, cycle index t within a run (0 = idle), written mask, captured beats.
    int       ma [4];
    int       mb [4];
    int       t = 0;
    logic [7:0] mask = 8'h00;
    int       oa0 [3];
    int       oa1 [3];
    int       ob0 [3];
    int       ob1 [3];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic auto_full();
`ifdef SYSTOLIC_FEEDER_AUTO_START_EN
        return (mask == 8'hFF);
`else
        return 1'b0;
`endif
    endfunction

    // Expected outputs for cycle tt of a run: 1 clear, 2..4 beats, then D drain cycles, then done.
    function automatic logic [4*W+3:0] exp_out(input int tt);
        int k;
        logic [W-1:0] a0, a1, b0, b1;
        k  = tt - 2;
        a0 = '0; a1 = '0; b0 = '0; b1 = '0;
        if (k == 0 || k == 1) begin
            a0 = W'(ma[k]);
            b0 = W'(mb[2*k]);
        end
        if (k == 1 || k == 2) begin
            a1 = W'(ma[2 + k - 1]);
            b1 = W'(mb[2*(k-1) + 1]);
        end
        return {tt == 1, (tt >= 1 && tt <= 4 + D), tt == 5 + D, (tt >= 2 && tt <= 4), a0, a1, b0, b1};
    endfunction

    // Push the captured beats through an ideal 2x2 output-stationary array and compare with A x B.
    task automatic check_product();
        int c [4];
        int e [4];
        c[0] = oa0[0]*ob0[0] + oa0[1]*ob0[1] + oa0[2]*ob0[2];
        c[1] = oa0[0]*ob1[1] + oa0[1]*ob1[2];
        c[2] = oa1[1]*ob0[0] + oa1[2]*ob0[1];
        c[3] = oa1[0]*ob1[0] + oa1[1]*ob1[1] + oa1[2]*ob1[2];
        for (int i = 0; i < 2; i++)
            for (int j = 0; j < 2; j++)
                e[i*2+j] = ma[i*2]*mb[j] + ma[i*2+1]*mb[2+j];
        for (int i = 0; i < 4; i++)
            check($sformatf("c%0d%0d", i/2, i%2), 64'(c[i]), 64'(e[i]));
    endtask

    task automatic step(input logic st, input logic lv, input logic ls, input logic [1:0] la, input logic [W-1:0] ld);
        logic full, rdy;
        start_i = st; load_valid_i = lv; load_sel_i = ls; load_addr_i = la; load_data_i = ld;
        full = auto_full();
        rdy  = (t == 0) && !st && !full;
        #1;
        check("load_ready", 64'(load_ready_o), 64'(rdy));
        @(posedge clk_i);
        if (t == 0) begin
            if (st || full) begin
                t = 1;
                mask = 8'h00;
            end else if (lv) begin
                if (ls) mb[la] = int'(ld);
                else    ma[la] = int'(ld);
                mask[{ls, la}] = 1'b1;
            end
        end else if (t == 5 + D) begin
            t = 0;
        end else begin
            t++;
        end
        #1;
        check("outputs", 64'(obs_s), 64'(exp_out(t)));
        if (t == 1) begin
            for (int i = 0; i < 3; i++) begin
                oa0[i] = 0; oa1[i] = 0; ob0[i] = 0; ob1[i] = 0;
            end
        end
        if (t >= 2 && t <= 4) begin
            oa0[t-2] = int'(a_data0_o); oa1[t-2] = int'(a_data1_o);
            ob0[t-2] = int'(b_data0_o); ob1[t-2] = int'(b_data1_o);
        end
        if (t == 5 + D) check_product();
    endtask

    task automatic do_reset(input int cyc);
        rst_ni = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ma[i] = 0;
            mb[i] = 0;
        end
        t = 0;
        mask = 8'h00;
        #1;
        check("rst_out", 64'(obs_s), 64'd0);
        check("rst_ready", 64'(load_ready_o), 64'(!start_i));
        repeat (cyc) @(posedge clk_i);
        #2;
        rst_ni = 1'b1;
        #1;
        check("rst_release", 64'(obs_s), 64'd0);
    endtask

    task automatic run_idle(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b0, 2'd0, '0);
    endtask

    task automatic load_all(input logic rnd);
        for (int i = 0; i < 8; i++)
            step(1'b0, 1'b1, i[2], i[1:0], rnd ? W'($urandom) : W'(i + 1));
    endtask

    initial begin
        #2;
        do_reset(3);
        run_idle(2);

        // A = [[1,2],[3,4]], B = [[5,6],[7,8]]; start/load collisions while busy.
        load_all(1'b0);
        step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        step(1'b0, 1'b0, 1'b0, 2'd0, '0);
        step(1'b1, 1'b1, 1'b0, 2'd1, 8'd77);
        step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        run_idle(5 + D);

        // start and load together in idle: load dropped, run begins with old operands
        step(1'b1, 1'b1, 1'b0, 2'd0, 8'd99);
        run_idle(6 + D);

        // seven writes only, then idle
        for (int i = 0; i < 7; i++) step(1'b0, 1'b1, i[2], i[1:0], W'($urandom));
        run_idle(4);

        // reset during beat 1, then a clean run on fresh operands
        load_all(1'b1);
        step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        run_idle(2);
        do_reset(1);
        run_idle(2);
        load_all(1'b1);
        step(1'b1, 1'b0, 1'b0, 2'd0, '0);
        run_idle(6 + D);

        for (int n = 0; n < 800; n++) begin
            if ($urandom_range(0, 299) == 0)
                do_reset(2);
            else
                step($urandom_range(0, 9) == 0, $urandom_range(0, 1) == 1, 1'($urandom_range(0, 1)),
                     2'($urandom_range(0, 3)), W'($urandom));
        end
        run_idle(8 + D);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/systolic_feeder_2x2.md
Name: systolic_feeder_2x2

Overview:
Upstream operand sequencer for the 2x2 systolic array. It captures the two 2x2 operand matrices A and B through a simple valid/ready load port. On start, it pulses an accumulator clear, then drives the array's row and column inputs with the diagonal skew the array needs. It then waits a fixed drain interval and signals done, at which point the array's c00..c11 hold A x B.

Parameters:
WIDTH, 8, operand element width; matches the array operand width
DRAIN_CYCLES, 2, idle cycles after the last feed beat before done; range 1..15

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-low reset
load_valid  input  1  load request for one matrix element
load_ready  output  1  element accepted when load_valid && load_ready at a clk edge
load_sel  input  1  target matrix: 0 = A, 1 = B
load_addr  input  2  element index = row*2 + col
load_data  input  WIDTH  element value
start  input  1  begin a multiply run; sampled only in IDLE
busy  output  1  high in CLEAR, FEED and DRAIN
done  output  1  one-cycle pulse in DONE
acc_clear  output  1  one-cycle pulse, drives the array's accumulator clear
a_data0  output  WIDTH  array row-0 operand
a_data1  output  WIDTH  array row-1 operand
b_data0  output  WIDTH  array column-0 operand
b_data1  output  WIDTH  array column-1 operand
valid_out  output  1  drives the array's valid_in

Behaviour:
- Reset (rst low, asynchronous): state = IDLE. All 8 stored elements = 0. All outputs = 0 except load_ready. load_ready follows IDLE decode (1 while rst is low, start low). Reset mid-run aborts immediately, with no done pulse.
- Storage: A[0..3] and B[0..3], WIDTH-bit flops each. A write sets element [load_sel][load_addr] = load_data. Elements persist across runs until overwritten or reset.
- load_ready = (state == IDLE) && !start. start has priority over a load in the same cycle. A load with load_ready low is ignored, not queued.
- FSM states and transitions: IDLE -> CLEAR (start = 1) -> FEED (always) -> DRAIN (after beat k = 2) -> DONE (after DRAIN_CYCLES cycles) -> IDLE. DONE lasts one cycle.
- start outside IDLE is ignored.
- Timing: start sampled at edge N. CLEAR occupies cycle N+1. FEED beats k = 0, 1, 2 occupy cycles N+2..N+4. DRAIN occupies N+5..N+4+DRAIN_CYCLES. DONE occupies the following cycle.
- All feed outputs, acc_clear, busy and done are registered. Each reflects the state it names during that state's cycle.
- acc_clear = 1 only in CLEAR.
- valid_out = 1 in all three FEED beats, otherwise 0.
- Feed skew per beat k:
  - a_data0 = A[0*2+k] for k < 2, else 0
  - a_data1 = A[1*2+(k-1)] for 1 <= k <= 2, else 0
  - b_data0 = B[k*2+0] for k < 2, else 0
  - b_data1 = B[(k-1)*2+1] for 1 <= k <= 2, else 0
- Outside FEED, all four data outputs are 0.
- Beat counter: 2 bits. Drain counter: 4 bits. Both are cleared on FEED/DRAIN entry, with no wrap hazard.
- Back-to-back runs: start asserted in the cycle after DONE (IDLE) begins the next run immediately.

Optional Feature:
SYSTOLIC_FEEDER_AUTO_START_EN
- Defined: an 8-bit written mask sets one bit per accepted load and is cleared on CLEAR entry and on reset. When the mask reaches 8'hFF in IDLE, the FSM enters CLEAR on the next edge exactly as if start were high. load_ready drops in that cycle. The start port still works.
- Not defined: no mask logic; runs begin only on start.

Test Plan:
- Reset: hold rst low for 3 cycles, then release -> all data outputs 0, valid_out/busy/done/acc_clear 0, load_ready 1.
- Load A = [[1,2],[3,4]] and B = [[5,6],[7,8]], then start -> CLEAR with acc_clear 1, then three FEED beats (a0,a1,b0,b1) = (1,0,5,0), (2,3,7,6), (0,4,0,8) with valid_out 1. Done arrives DRAIN_CYCLES + 1 cycles after the last beat. With the array attached: c00 = 19, c01 = 22, c10 = 43, c11 = 50.
- Start and load_valid high together in IDLE -> load not accepted (load_ready 0), run starts, stored element unchanged.
- Load during FEED -> load_ready 0, element unchanged. start pulses during busy -> no extra run and exactly one done.
- rst low during FEED beat 1 -> outputs 0 immediately, state IDLE, no done. A subsequent run after reloading operands gives correct results.
- With SYSTOLIC_FEEDER_AUTO_START_EN, write all 8 elements with start low -> CLEAR begins the cycle after the 8th accepted write. Writing only 7 elements -> stays IDLE.
